// File: rtl/ham_enc_seq_if.sv
// Data-memory and req/done bundle between ham_enc_seq and its host.
// The master modport is taken by the sequencer, the slave modport by the host.
interface ham_enc_seq_if #(
  parameter int AW = 8
);
  logic          req;
  logic          done;
  logic          busy;
  logic          mem_own;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data;
  logic [3:0]    err_cnt;

  modport master (
    input  req, mem_rd_data,
    output done, busy, mem_own, mem_addr, mem_wr_en, mem_wr_data, err_cnt
  );

  modport slave (
    output req, mem_rd_data,
    input  done, busy, mem_own, mem_addr, mem_wr_en, mem_wr_data, err_cnt
  );
endinterface

// File: rtl/ham_enc_seq.sv
// Hamming (16,11) SECDED block encoder: reads MSG_COUNT messages, writes codewords.
// Define HAM_RDBACK_EN to add a read-back VERIFY pass and the err_cnt counter.
module ham_enc_seq #(
  parameter int MSG_COUNT = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ham_enc_seq_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_VF_LO, S_VF_HI, S_DONE
  } state_e;

  localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);
  localparam logic [3:0]    LAST_IDX = 4'(MSG_COUNT - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [11:1] data_q, data_d;
`ifdef HAM_RDBACK_EN
  logic [3:0]  err_q, err_d;
  logic        mism_q, mism_d;
`endif

  logic          advance;
  logic [AW-1:0] offset, src_lo, dst_lo;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          p8, p4, p2, p1, p0;
  logic [7:0]    cw_lo, cw_hi;

  assign offset = AW'({idx_q, 1'b0});
  assign src_lo = SRC_A + offset;
  assign dst_lo = DST_A + offset;

  assign p8    = ^data_q[11:5];
  assign p4    = (^data_q[11:8]) ^ (^data_q[4:2]);
  assign p2    = data_q[11] ^ data_q[10] ^ data_q[7] ^ data_q[6] ^ data_q[4] ^ data_q[3] ^ data_q[1];
  assign p1    = data_q[11] ^ data_q[9] ^ data_q[7] ^ data_q[5] ^ data_q[4] ^ data_q[2] ^ data_q[1];
  assign p0    = (^data_q) ^ p8 ^ p4 ^ p2 ^ p1;
  assign cw_lo = {data_q[4:2], p4, data_q[1], p2, p1, p0};
  assign cw_hi = {data_q[11:5], p8};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr    = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    advance = 1'b0;
`ifdef HAM_RDBACK_EN
    err_d   = err_q;
    mism_d  = mism_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.req) begin
          state_d = S_RD_LO;
          idx_d   = '0;
`ifdef HAM_RDBACK_EN
          err_d   = '0;
`endif
        end
      end
      S_RD_LO: begin
        addr        = src_lo;
        data_d[8:1] = bus.mem_rd_data;
        state_d     = S_RD_HI;
      end
      S_RD_HI: begin
        addr         = src_lo + AW'(1);
        data_d[11:9] = bus.mem_rd_data[2:0];
        state_d      = S_WR_LO;
      end
      S_WR_LO: begin
        addr    = dst_lo;
        wr_en   = 1'b1;
        wr_data = cw_lo;
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        addr    = dst_lo + AW'(1);
        wr_en   = 1'b1;
        wr_data = cw_hi;
`ifdef HAM_RDBACK_EN
        state_d = S_VF_LO;
`else
        advance = 1'b1;
`endif
      end
`ifdef HAM_RDBACK_EN
      S_VF_LO: begin
        addr    = dst_lo;
        mism_d  = (bus.mem_rd_data != cw_lo);
        state_d = S_VF_HI;
      end
      S_VF_HI: begin
        addr    = dst_lo + AW'(1);
        advance = 1'b1;
        if ((mism_q || (bus.mem_rd_data != cw_hi)) && (err_q != 4'd15)) err_d = err_q + 4'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_RD_LO;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef HAM_RDBACK_EN
      err_q   <= '0;
      mism_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef HAM_RDBACK_EN
      err_q   <= err_d;
      mism_q  <= mism_d;
`endif
    end
  end

  assign bus.done        = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.mem_own     = bus.busy;
  assign bus.mem_addr    = addr;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_data = wr_data;
`ifdef HAM_RDBACK_EN
  assign bus.err_cnt     = err_q;
`else
  assign bus.err_cnt     = 4'd0;
`endif

endmodule

// File: tb/tb_ham_enc_seq.sv
// Self-checking bench for ham_enc_seq: directed codeword table, random block,
// busy-req rejection, DONE restart, mid-block reset abort and (optionally) read-back errors.
module tb_ham_enc_seq;
  localparam int AW  = 8;
  localparam int N   = 15;
  localparam int SRC = 0;
  localparam int DST = 30;
`ifdef HAM_RDBACK_EN
  localparam int CYC = 6;
`else
  localparam int CYC = 4;
`endif
  localparam int LAT = CYC * N + 1;

  typedef struct {
    logic [7:0] s_lo;
    logic [7:0] s_hi;
    logic [7:0] e_lo;
    logic [7:0] e_hi;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ham_enc_seq_if #(.AW(AW)) bus ();

  ham_enc_seq #(
    .MSG_COUNT(N), .SRC_BASE(SRC), .DST_BASE(DST), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem      [256];
  logic [7:0] src_copy [2*N];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  logic stuck_en = 1'b0;
  logic [7:0] stuck_addr = '0;

  // Combinational-read memory; an optional stuck-at-1 on bit 0 of one address.
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk)
    if (bus.mem_wr_en)
      mem[bus.mem_addr] <= (stuck_en && bus.mem_addr == stuck_addr) ?
                           (bus.mem_wr_data | 8'h01) : bus.mem_wr_data;
  always @(negedge clk) if (bus.mem_wr_en) wr_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder in classic position form: parity pk covers positions with bit k set.
  function automatic logic [15:0] enc(input logic [11:1] d);
    logic [15:0] cw;
    logic        par;
    cw     = '0;
    cw[3]  = d[1];
    cw[5]  = d[2];
    cw[6]  = d[3];
    cw[7]  = d[4];
    for (int k = 5; k <= 11; k++) cw[k+4] = d[k];
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int i = 1; i < 16; i++) if ((i & p) != 0) par ^= cw[i];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic clear_dst();
    for (int i = 0; i < 2*N; i++) mem[DST+i] = 8'hA5;
  endtask

  task automatic check_block(input string tag, input int n_msgs);
    logic [15:0] cw;
    for (int i = 0; i < n_msgs; i++) begin
      cw = enc({mem[SRC+2*i+1][2:0], mem[SRC+2*i]});
      check($sformatf("%s_lo%0d", tag, i), 32'(mem[DST+2*i]),   32'(cw[7:0]));
      check($sformatf("%s_hi%0d", tag, i), 32'(mem[DST+2*i+1]), 32'(cw[15:8]));
    end
  endtask

  // Pulses req for one cycle and counts edges until done; req is sampled at the edge counted as 1.
  task automatic run_block(input int busy_req_at, input int abort_at, output int lat);
    bit fin;
    fin = 1'b0;
    lat = -1;
    @(posedge clk); #1 bus.req = 1'b1;
    for (int c = 1; c <= LAT + 20 && !fin; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.req = 1'b0;
        check("start_done_low", 32'(bus.done), 32'd0);
        check("start_busy",     32'(bus.busy), 32'd1);
        check("start_addr",     32'(bus.mem_addr), 32'(SRC));
      end
      if (c == 3) begin
        check("wr_lo_en",   32'(bus.mem_wr_en), 32'd1);
        check("wr_lo_addr", 32'(bus.mem_addr),  32'(DST));
      end
      if (c == busy_req_at)     bus.req = 1'b1;
      if (c == busy_req_at + 1) bus.req = 1'b0;
      if (c == abort_at) begin
        reset = 1'b0;
        fin   = 1'b1;
      end else if (bus.done) begin
        lat = c;
        fin = 1'b1;
      end
    end
  endtask

  vec_t vecs [6];
  int   lat;
  int   cnt;

  initial begin
    vecs = '{
      '{8'h00, 8'h00, 8'h00, 8'h00},
      '{8'hFF, 8'h07, 8'hFF, 8'hFF},
      '{8'h01, 8'h00, 8'h0F, 8'h00},
      '{8'h00, 8'h04, 8'h17, 8'h81},
      '{8'h00, 8'hFC, 8'h17, 8'h81},
      '{8'h55, 8'h05, 8'h5A, 8'hAA}
    };
    bus.req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_done",    32'(bus.done),        32'd0);
    check("rst_busy",    32'(bus.busy),        32'd0);
    check("rst_own",     32'(bus.mem_own),     32'd0);
    check("rst_wr_en",   32'(bus.mem_wr_en),   32'd0);
    check("rst_addr",    32'(bus.mem_addr),    32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_err",     32'(bus.err_cnt),     32'd0);
    reset = 1'b1;

    // Directed vectors in messages 0..5; the rest stay zero.
    for (int i = 0; i < 6; i++) begin
      mem[SRC+2*i]   = vecs[i].s_lo;
      mem[SRC+2*i+1] = vecs[i].s_hi;
    end
    clear_dst();
    run_block(0, 0, lat);
    check("vec_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("vec%0d_lo", i), 32'(mem[DST+2*i]),   32'(vecs[i].e_lo));
      check($sformatf("vec%0d_hi", i), 32'(mem[DST+2*i+1]), 32'(vecs[i].e_hi));
    end

    // Random block with a req pulse injected mid-run that must be ignored.
    for (int i = 0; i < 2*N; i++) begin
      mem[SRC+i]  = 8'($urandom);
      src_copy[i] = mem[SRC+i];
    end
    clear_dst();
    wr_cnt = 0;
    run_block(20, 0, lat);
    check("rand_latency", 32'(lat), 32'(LAT));
    check("rand_wr_cnt",  32'(wr_cnt), 32'(2*N));
    check("rand_err",     32'(bus.err_cnt), 32'd0);
    check_block("rand", N);
    for (int i = 0; i < 2*N; i++) check($sformatf("src_keep%0d", i), 32'(mem[SRC+i]), 32'(src_copy[i]));

    // req held high through DONE restarts immediately, then DONE holds once req drops.
    @(posedge clk); #1 bus.req = 1'b1;
    lat = -1;
    for (int c = 1; c <= LAT + 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) lat = c;
    end
    check("held_latency", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    check("held_restart_done", 32'(bus.done), 32'd0);
    check("held_restart_busy", 32'(bus.busy), 32'd1);
    bus.req = 1'b0;
    cnt = -1;
    for (int c = 1; c <= LAT + 20 && cnt < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) cnt = c;
    end
    check("held_second_pass", 32'(cnt), 32'(CYC*N));
    @(posedge clk); #1;
    check("done_holds", 32'(bus.done), 32'd1);

    // Reset during message 7's WR_LO aborts the block.
    for (int i = 0; i < 2*N; i++) mem[SRC+i] = 8'($urandom);
    clear_dst();
    run_block(0, CYC*7 + 3, lat);
    @(posedge clk); #1;
    check("abort_busy",  32'(bus.busy),      32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    check("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check_block("abort", 7);
    check("abort_msg8_lo", 32'(mem[DST+16]), 32'h0000_00A5);
    check("abort_msg8_hi", 32'(mem[DST+17]), 32'h0000_00A5);
    reset = 1'b1;
    run_block(0, 0, lat);
    check("rerun_latency", 32'(lat), 32'(LAT));
    check_block("rerun", N);

`ifdef HAM_RDBACK_EN
    // Message 0 encodes to 0x0000, so a stuck-at-1 on its low byte is a single mismatch.
    mem[SRC]   = 8'h00;
    mem[SRC+1] = 8'h00;
    stuck_addr = 8'(DST);
    stuck_en   = 1'b1;
    run_block(0, 0, lat);
    stuck_en   = 1'b0;
    check("rdback_latency", 32'(lat), 32'(LAT));
    check("rdback_err_cnt", 32'(bus.err_cnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
